// File: rtl/lc3_cc_pkg.sv
// Shared types and constants for the LC-3 condition-code and branch stage.
// Holds the NZP encoding, its reset value, the branch FSM states and a one-hot check.
package lc3_cc_pkg;

   typedef logic [2:0] nzp_t;

   localparam nzp_t NZP_N     = 3'b100;
   localparam nzp_t NZP_Z     = 3'b010;
   localparam nzp_t NZP_P     = 3'b001;
   localparam nzp_t NZP_RESET = NZP_Z;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } br_state_t;

   // Only the three legal condition codes pass; 000 and multi-hot values are rejected.
   function automatic logic nzp_is_onehot(input nzp_t v);
      return (v == NZP_N) || (v == NZP_Z) || (v == NZP_P);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: +1 per cycle with inc, sticks at all-ones, clr wins over inc.
// Single-cycle update, no handshake; the value is always observable on q.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/cc_branch_unit.sv
// LC-3 CC register and BR resolution: req -> EVAL -> RESP (ben valid two cycles after req).
// Result is held in RESP until br_ack; br_req outside IDLE is dropped, ld_cc is always accepted.
module cc_branch_unit
   import lc3_cc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [2:0]       nzp_next,
   input  logic             ld_cc,
   input  logic [15:0]      ir,
   input  logic             br_req,
   input  logic             br_ack,
   input  logic             cnt_clr,
   output logic [2:0]       nzp,
   output logic             ben,
   output logic             ben_valid,
   output logic             busy,
   output logic             cc_err,
   output logic [CNT_W-1:0] br_total,
   output logic [CNT_W-1:0] br_taken
);

   br_state_t state, state_nxt;
   nzp_t      mask;
   logic      ben_eval;
   logic      eval_done;
   logic      unused_ir;

   assign unused_ir = ^{ir[15:12], ir[8:0]};

   // Illegal codes leave nzp untouched so a later branch still sees the last good value.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         nzp    <= NZP_RESET;
         cc_err <= 1'b0;
      end else if (ld_cc) begin
         if (nzp_is_onehot(nzp_next)) begin
            nzp <= nzp_next;
         end else begin
            cc_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (br_req) state_nxt = EVAL;
         EVAL:    state_nxt = RESP;
         RESP:    if (br_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The condition is resolved against the nzp present during EVAL, so an ld_cc
   // in that same cycle only lands after the decision.
   assign ben_eval  = |(mask & nzp);
   assign eval_done = (state == EVAL);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mask <= '0;
         ben  <= 1'b0;
      end else begin
         if ((state == IDLE) && br_req) begin
            mask <= ir[11:9];
         end
         if (eval_done) begin
            ben <= ben_eval;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign ben_valid = (state == RESP);

   sat_counter #(.W(CNT_W)) u_total (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (cnt_clr),
      .inc   (eval_done),
      .q     (br_total)
   );

   sat_counter #(.W(CNT_W)) u_taken (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (cnt_clr),
      .inc   (eval_done & ben_eval),
      .q     (br_taken)
   );

endmodule

// File: tb/tb_cc_branch_unit.sv
// Randomised and directed bench for cc_branch_unit against a transaction-level model.
// Narrow counters keep the saturation case within a short run.
module tb_cc_branch_unit;

   localparam int TB_W = 4;
   localparam int CMAX = (1 << TB_W) - 1;

   logic            Clk = 1'b0;
   logic            Reset;
   logic [2:0]      nzp_next;
   logic            ld_cc;
   logic [15:0]     ir;
   logic            br_req;
   logic            br_ack;
   logic            cnt_clr;
   logic [2:0]      nzp;
   logic            ben;
   logic            ben_valid;
   logic            busy;
   logic            cc_err;
   logic [TB_W-1:0] br_total;
   logic [TB_W-1:0] br_taken;

   cc_branch_unit #(.CNT_W(TB_W)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .nzp_next  (nzp_next),
      .ld_cc     (ld_cc),
      .ir        (ir),
      .br_req    (br_req),
      .br_ack    (br_ack),
      .cnt_clr   (cnt_clr),
      .nzp       (nzp),
      .ben       (ben),
      .ben_valid (ben_valid),
      .busy      (busy),
      .cc_err    (cc_err),
      .br_total  (br_total),
      .br_taken  (br_taken)
   );

   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_mis = 0;

   // Reference state: architectural view only
   logic [2:0] m_nzp;
   logic       m_err;
   int         m_total;
   int         m_taken;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic void model_reset();
      m_nzp   = 3'b010;
      m_err   = 1'b0;
      m_total = 0;
      m_taken = 0;
   endfunction

   function automatic void model_ld(input logic [2:0] v);
      if ($countones(v) == 1) m_nzp = v;
      else                    m_err = 1'b1;
   endfunction

   function automatic void model_count(input logic taken);
      if (m_total < CMAX) m_total++;
      if (taken && m_taken < CMAX) m_taken++;
   endfunction

   task automatic chk_arch(input string tag);
      chk({tag, ".nzp"},    int'(nzp),      int'(m_nzp));
      chk({tag, ".cc_err"}, int'(cc_err),   int'(m_err));
      chk({tag, ".total"},  int'(br_total), m_total);
      chk({tag, ".taken"},  int'(br_taken), m_taken);
   endtask

   task automatic do_ld(input logic [2:0] v);
      ld_cc    = 1'b1;
      nzp_next = v;
      tick();
      ld_cc    = 1'b0;
      model_ld(v);
      chk("ld.nzp",    int'(nzp),    int'(m_nzp));
      chk("ld.cc_err", int'(cc_err), int'(m_err));
   endtask

   task automatic do_clr();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      m_total = 0;
      m_taken = 0;
      chk("clr.total", int'(br_total), 0);
      chk("clr.taken", int'(br_taken), 0);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      #3;
      model_reset();
      Reset = 1'b0;
      tick();
   endtask

   // One complete branch transaction.
   task automatic do_branch(input logic [2:0] msk,
                            input logic       ld_req,  input logic [2:0] v_req,
                            input logic       ld_eval, input logic [2:0] v_eval,
                            input logic       clr_eval,
                            input int         hold,    input logic       pester);
      logic exp_ben;
      ir       = 16'($urandom);
      ir[11:9] = msk;
      br_req   = 1'b1;
      ld_cc    = ld_req;
      nzp_next = v_req;
      tick();
      br_req = 1'b0;
      ld_cc  = 1'b0;
      if (ld_req) model_ld(v_req);
      chk("eval.busy",      int'(busy),      1);
      chk("eval.ben_valid", int'(ben_valid), 0);

      exp_ben  = |(msk & m_nzp);
      ld_cc    = ld_eval;
      nzp_next = v_eval;
      cnt_clr  = clr_eval;
      ir       = 16'($urandom);
      tick();
      ld_cc   = 1'b0;
      cnt_clr = 1'b0;
      model_count(exp_ben);
      if (clr_eval) begin
         m_total = 0;
         m_taken = 0;
      end
      if (ld_eval) model_ld(v_eval);
      chk("resp.ben_valid", int'(ben_valid), 1);
      chk("resp.ben",       int'(ben),       int'(exp_ben));
      chk_arch("resp");

      for (int i = 0; i < hold; i++) begin
         br_req = pester;
         tick();
         chk("hold.ben",       int'(ben),       int'(exp_ben));
         chk("hold.ben_valid", int'(ben_valid), 1);
         chk("hold.total",     int'(br_total),  m_total);
      end

      br_ack = 1'b1;
      br_req = pester;
      tick();
      br_ack = 1'b0;
      br_req = 1'b0;
      chk("ack.ben_valid", int'(ben_valid), 0);
      chk("ack.busy",      int'(busy),      0);
      tick();
      chk("idle.busy", int'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset    = 1'b1;
      nzp_next = 3'b000;
      ld_cc    = 1'b0;
      ir       = 16'h0000;
      br_req   = 1'b0;
      br_ack   = 1'b0;
      cnt_clr  = 1'b0;
      model_reset();
      #12;
      chk("rst.nzp",       int'(nzp),       3'b010);
      chk("rst.ben",       int'(ben),       0);
      chk("rst.ben_valid", int'(ben_valid), 0);
      chk("rst.busy",      int'(busy),      0);
      chk("rst.cc_err",    int'(cc_err),    0);
      chk("rst.total",     int'(br_total),  0);
      chk("rst.taken",     int'(br_taken),  0);
      Reset = 1'b0;
      tick();

      // BRnzp straight after reset is taken
      do_branch(3'b111, 0, 3'b000, 0, 3'b000, 0, 0, 0);

      do_ld(3'b100);
      do_branch(3'b001, 0, 3'b000, 0, 3'b000, 0, 0, 0);
      do_branch(3'b100, 0, 3'b000, 0, 3'b000, 0, 0, 0);

      // ld_cc alongside br_req counts; ld_cc during EVAL does not
      do_branch(3'b001, 1, 3'b001, 0, 3'b000, 0, 0, 0);
      do_branch(3'b001, 0, 3'b000, 1, 3'b100, 0, 0, 0);
      chk("eval_ld.nzp", int'(nzp), 3'b100);

      // NOP mask never taken but counted
      do_branch(3'b000, 0, 3'b000, 0, 3'b000, 0, 0, 0);

      do_ld(3'b011);
      do_ld(3'b001);
      do_reset();
      chk_arch("rst2");
      do_ld(3'b000);
      do_ld(3'b010);

      // Hold RESP with ack withheld and requests ignored
      do_branch(3'b010, 0, 3'b000, 0, 3'b000, 0, 5, 1);

      // Saturation, then clear colliding with an increment
      do_clr();
      for (int i = 0; i < CMAX + 2; i++)
         do_branch(3'b111, 0, 3'b000, 0, 3'b000, 0, 0, 0);
      chk("sat.total", int'(br_total), CMAX);
      chk("sat.taken", int'(br_taken), CMAX);
      do_branch(3'b111, 0, 3'b000, 0, 3'b000, 1, 0, 0);
      chk("clrinc.total", int'(br_total), 0);
      chk("clrinc.taken", int'(br_taken), 0);

      // Stray ack in IDLE
      br_ack = 1'b1;
      tick();
      br_ack = 1'b0;
      chk("stray_ack.busy", int'(busy), 0);

      // Asynchronous reset during EVAL discards the evaluation
      do_branch(3'b111, 0, 3'b000, 0, 3'b000, 0, 0, 0);
      ir[11:9] = 3'b111;
      br_req   = 1'b1;
      tick();
      br_req = 1'b0;
      chk("pre_rst.busy", int'(busy), 1);
      #2;
      Reset = 1'b1;
      #1;
      model_reset();
      chk("async.busy",      int'(busy),      0);
      chk("async.ben_valid", int'(ben_valid), 0);
      chk_arch("async");
      @(negedge Clk);
      Reset = 1'b0;
      tick();
      tick();
      chk("post_rst.busy", int'(busy), 0);
      chk_arch("post_rst");

      // Randomised traffic
      for (int n = 0; n < 60; n++) begin
         logic [2:0] v1, v2, msk;
         v1  = 3'($urandom);
         v2  = 3'($urandom);
         msk = 3'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 3) == 0) do_ld(v1);
            else do_ld(3'b001 << $urandom_range(0, 2));
         end
         if ($urandom_range(0, 7) == 0) do_clr();
         do_branch(msk,
                   1'($urandom), 3'b001 << $urandom_range(0, 2),
                   1'($urandom), ($urandom_range(0, 4) == 0) ? v2 : 3'b001 << $urandom_range(0, 2),
                   ($urandom_range(0, 9) == 0),
                   $urandom_range(0, 3), 1'($urandom));
         chk_arch("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/cc_branch_unit.md
# cc_branch_unit

Condition-code and branch-resolution stage for the LC-3 datapath. It registers the one-hot NZP value produced by the combinational NZP setter when the control FSM asserts `ld_cc`. On a request/acknowledge handshake with the control FSM, it evaluates the BR condition field `ir[11:9]` against the stored codes and returns BEN. It also keeps saturating branch statistics counters for debug readout on the FPGA board.

## Interface
- `CNT_W`, default 16: width of the branch statistics counters.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `nzp_next`  in  3  one-hot {N,Z,P} from the NZP setter.
- `ld_cc`  in  1  load `nzp_next` into the CC register this cycle.
- `ir`  in  16  current instruction register; only `[11:9]` is used.
- `br_req`  in  1  control FSM requests branch evaluation.
- `br_ack`  in  1  control FSM consumes the result.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `nzp`  out  3  registered condition codes.
- `ben`  out  1  branch enable result.
- `ben_valid`  out  1  `ben` is valid and held.
- `busy`  out  1  FSM not in IDLE.
- `cc_err`  out  1  sticky flag: a non-one-hot `nzp_next` was presented with `ld_cc`.
- `br_total`  out  CNT_W  count of evaluations.
- `br_taken`  out  CNT_W  count of evaluations with `ben`=1.

## Operation
- CC register:
  - On `ld_cc`, if `nzp_next` is exactly one-hot, `nzp` <= `nzp_next`.
  - If `nzp_next` is not one-hot, `nzp` holds and `cc_err` <= 1.
  - `cc_err` stays set until `Reset`.
- `ld_cc` is accepted in every FSM state.
- FSM states:
  - IDLE → EVAL on `br_req`. The mask `ir[11:9]` is captured into an internal register on that edge.
  - EVAL → RESP unconditionally. On this edge, `ben` <= |(mask & `nzp`), using the `nzp` register value present during EVAL.
  - RESP → IDLE on `br_ack`. Otherwise the FSM holds and `ben` is stable.
- `br_req` outside IDLE is ignored; it is not queued.
- `busy` = (state != IDLE). `ben_valid` = (state == RESP).
- Counters:
  - On the EVAL→RESP edge, `br_total` += 1, and `br_taken` += 1 if the new `ben` is 1.
  - Both counters saturate at all-ones with no wrap.
  - `cnt_clr` has priority over an increment in the same cycle.
- Reset values:
  - `nzp` = 3'b010 (Z), so BRnzp after reset is taken.
  - `ben` = 0, `ben_valid` = 0, `busy` = 0, `cc_err` = 0, both counters = 0, state = IDLE, mask = 0.
- Mask 3'b000 (NOP encoding) always yields `ben` = 0 but is still counted in `br_total`.

## Timing
- `ld_cc` at edge T makes the new `nzp` visible in cycle T+1.
- `br_req` sampled at edge T puts the FSM in EVAL for cycle T+1.
- `ben` and `ben_valid` are asserted from cycle T+2. Minimum latency is 2 cycles.
- `ld_cc` in the same cycle as `br_req` (cycle T) is included in the evaluation.
- `ld_cc` during the EVAL cycle is not included in the current evaluation; it affects the next evaluation only.
- `br_ack` in the first RESP cycle returns the FSM to IDLE at the next edge. `ben_valid` is high for exactly 1 cycle in that case.
- `br_req` in the same cycle as the RESP→IDLE transition is ignored. A back-to-back request needs `br_req` held one more cycle. Maximum throughput is 1 evaluation per 3 cycles.
- `br_ack` outside RESP is ignored.
- `Reset` asserted mid-operation:
  - The FSM returns to IDLE and `ben_valid` drops immediately (asynchronous).
  - The in-flight evaluation is discarded and not counted.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Package `lc3_cc_pkg`:
  - `typedef logic [2:0] nzp_t`.
  - Constants `NZP_N` = 3'b100, `NZP_Z` = 3'b010, `NZP_P` = 3'b001, `NZP_RESET` = `NZP_Z`.
  - Enum `br_state_t` {IDLE, EVAL, RESP}.
- Sub-module `sat_counter`:
  - Parameterised by `W`; ports `Clk`, `Reset`, `clr`, `inc`, `q`.
  - Instantiated twice, once for `br_total` and once for `br_taken`.
- One-hot check, CC register, FSM and mask register live in the top module.

## Test plan
- Reset → `nzp`=010, `ben_valid`=0, `busy`=0, both counters 0. Then `br_req` with `ir[11:9]`=111 → at T+2, `ben`=1, `ben_valid`=1, `br_taken`=1.
- `ld_cc` with `nzp_next`=100, then `br_req` with mask 001 → `ben`=0, `br_total`=1, `br_taken`=0. Repeat with mask 100 → `ben`=1, `br_taken`=1.
- `ld_cc` (`nzp_next`=001) in the same cycle as `br_req` (mask 001) → `ben`=1. Separately, `ld_cc` (`nzp_next`=100) during EVAL with `nzp`=001 and mask 001 → `ben`=1, and `nzp`=100 afterwards.
- `ld_cc` with `nzp_next`=011 → `nzp` unchanged and `cc_err`=1, still 1 after a later valid `ld_cc`. Check `nzp_next`=000 the same way.
- Hold RESP for 5 cycles without `br_ack` → `ben` stable, extra `br_req` ignored, `br_total` incremented once. `br_ack` → IDLE next edge.
- Force counters to all-ones and evaluate a taken branch → both stay all-ones. Assert `cnt_clr` and an increment together → both 0. `Reset` during EVAL → IDLE, no count increment.
